alu_ctrl_mc: RTL and testbench

ALU_CTRL_MC -- requirements
Module: alu_ctrl_mc

---
 rtl/alu_ctrl_mc.sv | 222 ++++++++++++++++++++++
 tb/tb_alu_ctrl_mc.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_mc.sv
// ALU control decoder with a registered decode stage and a multi-cycle
// occupancy tracker that stalls upstream during multiply/divide.
module alu_ctrl_mc #(
    parameter int FUNCTION_SIZE = 6,
    parameter int ALU_OP_SIZE   = 6,
    parameter int ALU_CTRL_SIZE = 4,
    parameter int MUL_CYCLES    = 4,
    parameter int DIV_CYCLES    = 32,
    parameter int CNT_SIZE      = 6
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_valid,
    input  logic                     i_flush,
    input  logic [FUNCTION_SIZE-1:0] i_funct_code,
    input  logic [ALU_OP_SIZE-1:0]   i_alu_op,
    output logic [ALU_CTRL_SIZE-1:0] o_alu_ctrl,
    output logic                     o_shamt_ctrl,
    output logic                     o_last_register_ctrl,
    output logic                     o_unsigned,
    output logic                     o_valid,
    output logic                     o_illegal,
    output logic                     o_busy,
    output logic                     o_mc_done
);

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV} state_e;

    localparam logic [ALU_OP_SIZE-1:0] OP_RTYPE = ALU_OP_SIZE'(6'h00);
    localparam logic [ALU_OP_SIZE-1:0] OP_JAL   = ALU_OP_SIZE'(6'h03);
    localparam logic [ALU_OP_SIZE-1:0] OP_BEQ   = ALU_OP_SIZE'(6'h04);
    localparam logic [ALU_OP_SIZE-1:0] OP_BNE   = ALU_OP_SIZE'(6'h05);
    localparam logic [ALU_OP_SIZE-1:0] OP_ADDI  = ALU_OP_SIZE'(6'h08);
    localparam logic [ALU_OP_SIZE-1:0] OP_SLTI  = ALU_OP_SIZE'(6'h0A);
    localparam logic [ALU_OP_SIZE-1:0] OP_ANDI  = ALU_OP_SIZE'(6'h0C);
    localparam logic [ALU_OP_SIZE-1:0] OP_ORI   = ALU_OP_SIZE'(6'h0D);
    localparam logic [ALU_OP_SIZE-1:0] OP_XORI  = ALU_OP_SIZE'(6'h0E);
    localparam logic [ALU_OP_SIZE-1:0] OP_LUI   = ALU_OP_SIZE'(6'h0F);
    localparam logic [ALU_OP_SIZE-1:0] OP_LB    = ALU_OP_SIZE'(6'h20);
    localparam logic [ALU_OP_SIZE-1:0] OP_LH    = ALU_OP_SIZE'(6'h21);
    localparam logic [ALU_OP_SIZE-1:0] OP_LW    = ALU_OP_SIZE'(6'h23);
    localparam logic [ALU_OP_SIZE-1:0] OP_LBU   = ALU_OP_SIZE'(6'h24);
    localparam logic [ALU_OP_SIZE-1:0] OP_LHU   = ALU_OP_SIZE'(6'h25);
    localparam logic [ALU_OP_SIZE-1:0] OP_LWU   = ALU_OP_SIZE'(6'h27);
    localparam logic [ALU_OP_SIZE-1:0] OP_SB    = ALU_OP_SIZE'(6'h28);
    localparam logic [ALU_OP_SIZE-1:0] OP_SH    = ALU_OP_SIZE'(6'h29);
    localparam logic [ALU_OP_SIZE-1:0] OP_SW    = ALU_OP_SIZE'(6'h2B);

    localparam logic [ALU_CTRL_SIZE-1:0] C_SLL  = ALU_CTRL_SIZE'(4'h0);
    localparam logic [ALU_CTRL_SIZE-1:0] C_SRL  = ALU_CTRL_SIZE'(4'h1);
    localparam logic [ALU_CTRL_SIZE-1:0] C_SRA  = ALU_CTRL_SIZE'(4'h2);
    localparam logic [ALU_CTRL_SIZE-1:0] C_ADD  = ALU_CTRL_SIZE'(4'h3);
    localparam logic [ALU_CTRL_SIZE-1:0] C_SUB  = ALU_CTRL_SIZE'(4'h4);
    localparam logic [ALU_CTRL_SIZE-1:0] C_AND  = ALU_CTRL_SIZE'(4'h5);
    localparam logic [ALU_CTRL_SIZE-1:0] C_OR   = ALU_CTRL_SIZE'(4'h6);
    localparam logic [ALU_CTRL_SIZE-1:0] C_XOR  = ALU_CTRL_SIZE'(4'h7);
    localparam logic [ALU_CTRL_SIZE-1:0] C_NOR  = ALU_CTRL_SIZE'(4'h8);
    localparam logic [ALU_CTRL_SIZE-1:0] C_SLT  = ALU_CTRL_SIZE'(4'h9);
    localparam logic [ALU_CTRL_SIZE-1:0] C_LUI  = ALU_CTRL_SIZE'(4'hA);
    localparam logic [ALU_CTRL_SIZE-1:0] C_BEQ  = ALU_CTRL_SIZE'(4'hB);
    localparam logic [ALU_CTRL_SIZE-1:0] C_BNE  = ALU_CTRL_SIZE'(4'hC);
    localparam logic [ALU_CTRL_SIZE-1:0] C_MUL  = ALU_CTRL_SIZE'(4'hD);
    localparam logic [ALU_CTRL_SIZE-1:0] C_DIV  = ALU_CTRL_SIZE'(4'hE);

    state_e                   state_q, state_d;
    logic [CNT_SIZE-1:0]      cnt_q, cnt_d;
    logic [ALU_CTRL_SIZE-1:0] alu_ctrl_q, alu_ctrl_d;
    logic                     shamt_q, shamt_d;
    logic                     last_q, last_d;
    logic                     unsigned_q, unsigned_d;
    logic                     valid_q, valid_d;
    logic                     illegal_q, illegal_d;
    logic                     mc_done_q, mc_done_d;

    logic [ALU_CTRL_SIZE-1:0] dec_ctrl;
    logic                     dec_shamt, dec_last, dec_uns, dec_ill, dec_mul, dec_div;
    logic                     busy, accept;

    assign busy   = (state_q != ST_IDLE);
    assign accept = i_valid & ~busy & ~i_flush;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        dec_ctrl  = C_SLL;
        dec_shamt = 1'b1;
        dec_last  = 1'b0;
        dec_uns   = 1'b0;
        dec_ill   = 1'b0;
        dec_mul   = 1'b0;
        dec_div   = 1'b0;
        case (i_alu_op)
            OP_RTYPE: begin
                case (i_funct_code)
                    FUNCTION_SIZE'(6'h00): begin dec_ctrl = C_SLL; dec_shamt = 1'b0; end
                    FUNCTION_SIZE'(6'h02): begin dec_ctrl = C_SRL; dec_shamt = 1'b0; end
                    FUNCTION_SIZE'(6'h03): begin dec_ctrl = C_SRA; dec_shamt = 1'b0; end
                    FUNCTION_SIZE'(6'h04): dec_ctrl = C_SLL;
                    FUNCTION_SIZE'(6'h06): dec_ctrl = C_SRL;
                    FUNCTION_SIZE'(6'h07): dec_ctrl = C_SRA;
                    FUNCTION_SIZE'(6'h09): begin dec_ctrl = C_SLL; dec_shamt = 1'b0; dec_last = 1'b1; end
                    FUNCTION_SIZE'(6'h18): begin dec_ctrl = C_MUL; dec_mul = 1'b1; end
                    FUNCTION_SIZE'(6'h19): begin dec_ctrl = C_MUL; dec_mul = 1'b1; dec_uns = 1'b1; end
                    FUNCTION_SIZE'(6'h1A): begin dec_ctrl = C_DIV; dec_div = 1'b1; end
                    FUNCTION_SIZE'(6'h1B): begin dec_ctrl = C_DIV; dec_div = 1'b1; dec_uns = 1'b1; end
                    FUNCTION_SIZE'(6'h20), FUNCTION_SIZE'(6'h21): dec_ctrl = C_ADD;
                    FUNCTION_SIZE'(6'h22), FUNCTION_SIZE'(6'h23): dec_ctrl = C_SUB;
                    FUNCTION_SIZE'(6'h24): dec_ctrl = C_AND;
                    FUNCTION_SIZE'(6'h25): dec_ctrl = C_OR;
                    FUNCTION_SIZE'(6'h26): dec_ctrl = C_XOR;
                    FUNCTION_SIZE'(6'h27): dec_ctrl = C_NOR;
                    FUNCTION_SIZE'(6'h2A): dec_ctrl = C_SLT;
                    default:               dec_ill  = 1'b1;
                endcase
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LWU,
            OP_SB, OP_SH, OP_SW, OP_ADDI: dec_ctrl = C_ADD;
            OP_ANDI: dec_ctrl = C_AND;
            OP_ORI:  dec_ctrl = C_OR;
            OP_XORI: dec_ctrl = C_XOR;
            OP_SLTI: dec_ctrl = C_SLT;
            OP_LUI:  dec_ctrl = C_LUI;
            OP_BEQ:  dec_ctrl = C_BEQ;
            OP_BNE:  dec_ctrl = C_BNE;
            OP_JAL:  begin dec_ctrl = C_SLL; dec_last = 1'b1; end
            default: dec_ill = 1'b1;
        endcase
        // Undecodable instructions carry no control at all, only the illegal flag.
        if (dec_ill) begin
            dec_ctrl  = C_SLL;
            dec_shamt = 1'b0;
            dec_last  = 1'b0;
            dec_uns   = 1'b0;
            dec_mul   = 1'b0;
            dec_div   = 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mc_done_d = 1'b0;
        if (i_flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept && dec_mul) begin
                        state_d = ST_MUL;
                        cnt_d   = CNT_SIZE'(MUL_CYCLES - 1);
                    end else if (accept && dec_div) begin
                        state_d = ST_DIV;
                        cnt_d   = CNT_SIZE'(DIV_CYCLES - 1);
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (cnt_q <= CNT_SIZE'(1)) begin
                        state_d   = ST_IDLE;
                        mc_done_d = (cnt_q == CNT_SIZE'(1));
                    end
                    if (cnt_q != '0) cnt_d = cnt_q - CNT_SIZE'(1);
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Decoded fields only move on accept; otherwise they keep the last instruction.
    always_comb begin
        valid_d    = accept;
        alu_ctrl_d = alu_ctrl_q;
        shamt_d    = shamt_q;
        last_d     = last_q;
        unsigned_d = unsigned_q;
        illegal_d  = illegal_q;
        if (accept) begin
            alu_ctrl_d = dec_ctrl;
            shamt_d    = dec_shamt;
            last_d     = dec_last;
            unsigned_d = dec_uns;
            illegal_d  = dec_ill;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            alu_ctrl_q <= '0;
            shamt_q    <= 1'b0;
            last_q     <= 1'b0;
            unsigned_q <= 1'b0;
            valid_q    <= 1'b0;
            illegal_q  <= 1'b0;
            mc_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            alu_ctrl_q <= alu_ctrl_d;
            shamt_q    <= shamt_d;
            last_q     <= last_d;
            unsigned_q <= unsigned_d;
            valid_q    <= valid_d;
            illegal_q  <= illegal_d;
            mc_done_q  <= mc_done_d;
        end
    end

    assign o_alu_ctrl           = alu_ctrl_q;
    assign o_shamt_ctrl         = shamt_q;
    assign o_last_register_ctrl = last_q;
    assign o_unsigned           = unsigned_q;
    assign o_valid              = valid_q;
    assign o_illegal            = illegal_q;
    assign o_busy               = busy;
    assign o_mc_done            = mc_done_q;

endmodule

// File: tb/tb_alu_ctrl_mc.sv
// Directed bench for alu_ctrl_mc: decode table, multi-cycle occupancy,
// flush and asynchronous reset behaviour.
module tb_alu_ctrl_mc;

    logic       clk;
    logic       rst;
    logic       i_valid;
    logic       i_flush;
    logic [5:0] i_funct_code;
    logic [5:0] i_alu_op;
    logic [3:0] o_alu_ctrl;
    logic       o_shamt_ctrl;
    logic       o_last_register_ctrl;
    logic       o_unsigned;
    logic       o_valid;
    logic       o_illegal;
    logic       o_busy;
    logic       o_mc_done;

    int total = 0;
    int bad   = 0;

    alu_ctrl_mc dut (
        .i_clk                (clk),
        .i_reset              (rst),
        .i_valid              (i_valid),
        .i_flush              (i_flush),
        .i_funct_code         (i_funct_code),
        .i_alu_op             (i_alu_op),
        .o_alu_ctrl           (o_alu_ctrl),
        .o_shamt_ctrl         (o_shamt_ctrl),
        .o_last_register_ctrl (o_last_register_ctrl),
        .o_unsigned           (o_unsigned),
        .o_valid              (o_valid),
        .o_illegal            (o_illegal),
        .o_busy               (o_busy),
        .o_mc_done            (o_mc_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Expected vector layout: {ctrl[3:0], shamt, last, unsigned, valid, illegal, busy, done}
    function automatic logic [10:0] e(input logic [3:0] ctrl, input logic sh, input logic last,
                                      input logic uns, input logic v, input logic ill,
                                      input logic busy, input logic done);
        return {ctrl, sh, last, uns, v, ill, busy, done};
    endfunction

    task automatic check(input string tag, input logic [10:0] exp);
        logic [10:0] obs;
        obs = {o_alu_ctrl, o_shamt_ctrl, o_last_register_ctrl, o_unsigned,
               o_valid, o_illegal, o_busy, o_mc_done};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b required=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn);
        i_valid      = v;
        i_alu_op     = op;
        i_funct_code = fn;
    endtask

    initial begin
        rst = 1'b1;
        i_flush = 1'b0;
        drive(1'b0, 6'h00, 6'h00);
        #12;
        check("reset", e(4'h0, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b0;

        drive(1'b1, 6'h08, 6'h00); tick();
        check("addi", e(4'h3, 1, 0, 0, 1, 0, 0, 0));
        drive(1'b1, 6'h00, 6'h07); tick();
        check("srav", e(4'h2, 1, 0, 0, 1, 0, 0, 0));
        drive(1'b1, 6'h00, 6'h00); tick();
        check("sll", e(4'h0, 0, 0, 0, 1, 0, 0, 0));
        drive(1'b1, 6'h0C, 6'h00); tick();
        check("andi", e(4'h5, 1, 0, 0, 1, 0, 0, 0));
        drive(1'b0, 6'h00, 6'h00); tick();
        check("idle_hold", e(4'h5, 1, 0, 0, 0, 0, 0, 0));

        drive(1'b1, 6'h00, 6'h18); tick();
        check("mult_c1", e(4'hD, 1, 0, 0, 1, 0, 1, 0));
        drive(1'b1, 6'h00, 6'h20); tick();
        check("mult_c2", e(4'hD, 1, 0, 0, 0, 0, 1, 0));
        tick();
        check("mult_c3", e(4'hD, 1, 0, 0, 0, 0, 1, 0));
        tick();
        check("mult_done", e(4'hD, 1, 0, 0, 0, 0, 0, 1));
        tick();
        check("add_after_mult", e(4'h3, 1, 0, 0, 1, 0, 0, 0));

        drive(1'b1, 6'h00, 6'h19); tick();
        check("multu_c1", e(4'hD, 1, 0, 1, 1, 0, 1, 0));
        drive(1'b1, 6'h00, 6'h18); tick(); tick(); tick();
        check("multu_done", e(4'hD, 1, 0, 1, 0, 0, 0, 1));
        tick();
        check("b2b_mult_c1", e(4'hD, 1, 0, 0, 1, 0, 1, 0));
        drive(1'b0, 6'h00, 6'h00); tick(); tick(); tick();
        check("b2b_mult_done", e(4'hD, 1, 0, 0, 0, 0, 0, 1));
        tick();
        check("done_pulse_end", e(4'hD, 1, 0, 0, 0, 0, 0, 0));

        drive(1'b1, 6'h00, 6'h1B); tick();
        check("divu_c1", e(4'hE, 1, 0, 1, 1, 0, 1, 0));
        drive(1'b0, 6'h00, 6'h00);
        repeat (9) tick();
        check("divu_c10", e(4'hE, 1, 0, 1, 0, 0, 1, 0));
        i_flush = 1'b1;
        drive(1'b1, 6'h00, 6'h20); tick();
        check("flush", e(4'hE, 1, 0, 1, 0, 0, 0, 0));
        i_flush = 1'b0; tick();
        check("post_flush_add", e(4'h3, 1, 0, 0, 1, 0, 0, 0));
        drive(1'b0, 6'h00, 6'h00);
        repeat (25) tick();
        check("no_done_after_flush", e(4'h3, 1, 0, 0, 0, 0, 0, 0));

        drive(1'b1, 6'h3F, 6'h00); tick();
        check("illegal_op", e(4'h0, 0, 0, 0, 1, 1, 0, 0));
        drive(1'b1, 6'h00, 6'h3F); tick();
        check("illegal_fn", e(4'h0, 0, 0, 0, 1, 1, 0, 0));
        drive(1'b1, 6'h03, 6'h00); tick();
        check("jal", e(4'h0, 1, 1, 0, 1, 0, 0, 0));
        drive(1'b1, 6'h00, 6'h09); tick();
        check("jalr", e(4'h0, 0, 1, 0, 1, 0, 0, 0));
        drive(1'b1, 6'h0E, 6'h00); tick();
        check("xori", e(4'h7, 1, 0, 0, 1, 0, 0, 0));
        drive(1'b1, 6'h00, 6'h2A); tick();
        check("slt", e(4'h9, 1, 0, 0, 1, 0, 0, 0));
        drive(1'b1, 6'h05, 6'h00); tick();
        check("bne", e(4'hC, 1, 0, 0, 1, 0, 0, 0));

        drive(1'b1, 6'h00, 6'h1A); tick();
        check("div_c1", e(4'hE, 1, 0, 0, 1, 0, 1, 0));
        drive(1'b0, 6'h00, 6'h00); tick(); tick();
        #2 rst = 1'b1;
        #1;
        check("async_reset", e(4'h0, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b0;
        tick();
        check("after_reset_idle", e(4'h0, 0, 0, 0, 0, 0, 0, 0));
        drive(1'b1, 6'h08, 6'h00); tick();
        check("addi_after_reset", e(4'h3, 1, 0, 0, 1, 0, 0, 0));
        drive(1'b0, 6'h00, 6'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
